// File: rtl/fmu_pkg.sv
// Shared types and constants for the FMU issue sequencer and its result FIFO.
package fmu_pkg;

  localparam int FMU_DW  = 32;
  localparam int FMU_LAT = 4;

  typedef enum logic {
    ST_DRAIN,
    ST_RUN
  } state_t;

  // Ceiling log2, usable in constant expressions (port and parameter widths).
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fmu_res_fifo.sv
// Synchronous result FIFO: DW x DEPTH, explicit occupancy count, pointers wrap mod DEPTH.
module fmu_res_fifo
  import fmu_pkg::*;
#(
  parameter int DW    = FMU_DW,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count define validity,
  // which keeps the array as plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fmu_issue_seq.sv
// Issue sequencer for the pipelined FMU: credit-gated operand issue, result capture into a
// FIFO, and a post-reset drain window that discards completions launched before reset.
module fmu_issue_seq
  import fmu_pkg::*;
#(
  parameter int DW        = FMU_DW,
  parameter int LAT       = FMU_LAT,
  parameter int RES_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DW-1:0]              in_a,
  input  logic [DW-1:0]              in_b,
  output logic                       fmu_start,
  output logic [DW-1:0]              fmu_a,
  output logic [DW-1:0]              fmu_b,
  input  logic                       fmu_done,
  input  logic [DW-1:0]              fmu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DW-1:0]              out_result,
  output logic [clog2(RES_DEPTH):0]  inflight,
  output logic                       busy,
  output logic                       err
);

  localparam int CW  = clog2(RES_DEPTH) + 1;
  localparam int DCW = clog2(LAT + 2);

  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  credits;
  logic           fifo_full;
  logic           fifo_empty;
  logic           issue;
  logic           pop;
  logic           done_run;
  logic           done_bad;
  logic           done_ok;

  // Every issued op owns a FIFO slot until popped, so the FIFO can never overflow.
  assign credits   = CW'(RES_DEPTH) - inflight - fifo_count;
  assign in_ready  = (state == ST_RUN) && (credits != '0);
  assign issue     = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  assign done_run  = fmu_done && (state == ST_RUN);
  assign done_bad  = done_run && ((inflight == '0) || (fifo_full && !pop));
  assign done_ok   = done_run && !done_bad;

  assign busy      = (inflight != '0) || !fifo_empty || (state == ST_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_DRAIN;
      drain_cnt <= DCW'(LAT + 1);
      fmu_start <= 1'b0;
      fmu_a     <= '0;
      fmu_b     <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else begin
      fmu_start <= issue;
      if (issue) begin
        fmu_a <= in_a;
        fmu_b <= in_b;
      end

      // The FMU controller is not reset, so ops launched before rst may still
      // complete; DRAIN outlasts the pipeline latency and ignores those pulses.
      unique case (state)
        ST_DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - DCW'(1);
          if (drain_cnt <= DCW'(1)) state <= ST_RUN;
        end
        ST_RUN: state <= ST_RUN;
        default: state <= ST_DRAIN;
      endcase

      unique case ({issue, done_ok})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase

      if (done_bad) err <= 1'b1;
    end
  end

  fmu_res_fifo #(
    .DW    (DW),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (done_ok),
    .pop   (pop),
    .wdata (fmu_result),
    .rdata (out_result),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_fmu_issue_seq.sv
// Directed bench for fmu_issue_seq with a behavioural FMU pipeline model that returns
// table-supplied results LAT cycles after each start pulse.
module tb_fmu_issue_seq;
  import fmu_pkg::*;

  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int IW    = clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
  } op_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic          fmu_start;
  logic [DW-1:0] fmu_a;
  logic [DW-1:0] fmu_b;
  logic          fmu_done;
  logic [DW-1:0] fmu_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_result;
  logic [IW-1:0] inflight;
  logic          busy;
  logic          err;

  int total = 0;
  int bad   = 0;

  fmu_issue_seq #(
    .DW        (DW),
    .LAT       (LAT),
    .RES_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .fmu_start  (fmu_start),
    .fmu_a      (fmu_a),
    .fmu_b      (fmu_b),
    .fmu_done   (fmu_done),
    .fmu_result (fmu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .inflight   (inflight),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FMU pipeline model: not reset, so ops in flight across rst still complete.
  op_t           exp_q[$];
  op_t           m_e;
  logic [LAT-1:0] pipe_v = '0;
  logic [DW-1:0] pipe_d [LAT] = '{default: '0};
  logic          spur_done = 1'b0;
  logic [DW-1:0] spur_data = '0;

  assign fmu_done   = pipe_v[LAT-1] | spur_done;
  assign fmu_result = spur_done ? spur_data : pipe_d[LAT-1];

  always @(posedge clk) begin
    pipe_v <= {pipe_v[LAT-2:0], fmu_start};
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
    if (fmu_start) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL model_start: got unexpected fmu_start expected none");
        pipe_d[0] <= '0;
      end else begin
        m_e = exp_q.pop_front();
        check("start_a", fmu_a, m_e.a);
        check("start_b", fmu_b, m_e.b);
        pipe_d[0] <= m_e.res;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  op_t  tab [10];
  op_t  op;
  int   ix, rx, n, acc, stalls, gaps, starts;
  logic fire, started;

  initial begin
    tab[0] = '{32'h3F800000, 32'h3F800000, 32'h3F800000};  // 1 * 1 = 1
    tab[1] = '{32'h40000000, 32'h40000000, 32'h40800000};  // 2 * 2 = 4
    tab[2] = '{32'h3FC00000, 32'h40000000, 32'h40400000};  // 1.5 * 2 = 3
    tab[3] = '{32'h3F000000, 32'h40800000, 32'h40000000};  // 0.5 * 4 = 2
    tab[4] = '{32'h40400000, 32'h40400000, 32'h41100000};  // 3 * 3 = 9
    tab[5] = '{32'hBF800000, 32'h40000000, 32'hC0000000};  // -1 * 2 = -2
    tab[6] = '{32'h40000000, 32'h3E800000, 32'h3F000000};  // 2 * 0.25 = 0.5
    tab[7] = '{32'h40800000, 32'h40800000, 32'h41800000};  // 4 * 4 = 16
    tab[8] = '{32'h3F800000, 32'h00000000, 32'h00000000};  // 1 * 0 = 0
    tab[9] = '{32'h41000000, 32'h3F000000, 32'h40800000};  // 8 * 0.5 = 4

    // Reset state, then drain window with in_valid held and a stray done.
    in_valid = 1'b1;
    in_a = 32'h12345678;
    in_b = 32'h9ABCDEF0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fmu_start", fmu_start, 0);
    check("rst_fmu_a", fmu_a, 0);
    check("rst_fmu_b", fmu_b, 0);
    check("rst_inflight", inflight, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) break;
      n++;
      spur_done = (c == 2);
      spur_data = 32'hCAFEF00D;
      tick();
    end
    spur_done = 1'b0;
    in_valid  = 1'b0;
    check("drain_len", n, LAT + 1);
    check("drain_out_valid", out_valid, 0);
    check("drain_err", err, 0);
    check("drain_inflight", inflight, 0);

    // Single op: one start pulse, operands held, result after the pipeline.
    in_valid = 1'b1;
    in_a = 32'h40000000;
    in_b = 32'h40400000;
    exp_q.push_back('{32'h40000000, 32'h40400000, 32'h40C00000});
    tick();
    in_valid = 1'b0;
    check("single_start", fmu_start, 1);
    check("single_fmu_a", fmu_a, 32'h40000000);
    check("single_fmu_b", fmu_b, 32'h40400000);
    check("single_inflight", inflight, 1);
    n = 0;
    starts = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
      if (fmu_start) starts++;
    end
    check("single_latency", n, LAT + 1);
    check("single_restart", starts, 0);
    check("single_result", out_result, 32'h40C00000);
    check("single_inflight_done", inflight, 0);
    check("single_fmu_a_held", fmu_a, 32'h40000000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_popped", out_valid, 0);

    // Stream 10 ops with consumer stalled, then release: credits cap and order.
    acc = 0;
    ix = 0;
    rx = 0;
    for (int c = 0; c < 100 && rx < 10; c++) begin
      if (c == 20) begin
        check("t3_accepts", acc, DEPTH);
        check("t3_ready_blocked", in_ready, 0);
        check("t3_full_inflight", inflight, 0);
        out_ready = 1'b1;
      end
      in_valid = (ix < 10);
      if (ix < 10) begin
        in_a = tab[ix].a;
        in_b = tab[ix].b;
      end
      fire = in_valid && in_ready;
      if (fire) begin
        exp_q.push_back(tab[ix]);
        acc++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("t3_res%0d", rx), out_result, tab[rx].res);
        rx++;
      end
      tick();
      if (fire) ix++;
    end
    in_valid = 1'b0;
    check("t3_count", rx, 10);
    check("t3_err", err, 0);

    // Continuous issue: no stall, one result per cycle after fill.
    ix = 0;
    rx = 0;
    stalls = 0;
    gaps = 0;
    starts = 0;
    started = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && rx < 16; c++) begin
      if (fmu_start) starts++;
      in_valid = (ix < 16);
      op = '{32'h3F800000, 32'h40000000 + DW'(ix), 32'h40000000 + DW'(ix)};
      in_a = op.a;
      in_b = op.b;
      fire = in_valid && in_ready;
      if (in_valid && !in_ready) stalls++;
      if (fire) exp_q.push_back(op);
      if (out_valid) begin
        check($sformatf("t4_res%0d", rx), out_result, 32'h40000000 + 64'(rx));
        rx++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      tick();
      if (fire) ix++;
    end
    in_valid = 1'b0;
    check("t4_stalls", stalls, 0);
    check("t4_starts", starts, 16);
    check("t4_gaps", gaps, 0);
    check("t4_count", rx, 16);
    check("t4_idle_busy", busy, 0);

    // Spurious done in RUN with nothing in flight: sticky err, FIFO untouched.
    out_ready = 1'b0;
    spur_done = 1'b1;
    spur_data = 32'hDEADBEEF;
    tick();
    spur_done = 1'b0;
    check("spur_err", err, 1);
    check("spur_inflight", inflight, 0);
    tick();
    tick();
    tick();
    check("spur_err_sticky", err, 1);
    check("spur_no_push", out_valid, 0);

    // Reset with 3 in flight and 2 buffered; late dones dropped in DRAIN.
    acc = 0;
    ix = 0;
    for (int c = 0; c < 30 && acc < 5; c++) begin
      in_valid = 1'b1;
      in_a = tab[ix].a;
      in_b = tab[ix].b;
      fire = in_ready;
      if (fire) begin
        exp_q.push_back(tab[ix]);
        acc++;
      end
      tick();
      if (fire) ix++;
    end
    in_valid = 1'b0;
    n = 0;
    while (inflight != IW'(3) && n < 20) begin
      tick();
      n++;
    end
    check("t6_inflight3", inflight, 3);
    check("t6_buffered", out_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_inflight", inflight, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_fmu_a", fmu_a, 0);
    check("t6_rst_err", err, 0);
    tick();
    tick();
    rst = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("t6_drain_len", n, LAT + 1);
    check("t6_drop_out_valid", out_valid, 0);
    check("t6_drop_err", err, 0);
    check("t6_drop_inflight", inflight, 0);
    in_valid = 1'b1;
    in_a = 32'h40400000;
    in_b = 32'h3F000000;
    exp_q.push_back('{32'h40400000, 32'h3F000000, 32'h3FC00000});
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("t6_new_result", out_result, 32'h3FC00000);
    check("t6_new_valid", out_valid, 1);
    check("t6_new_err", err, 0);
    out_ready = 1'b1;
    tick();
    check("t6_new_popped", out_valid, 0);
    check("t6_model_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
